// File: rtl/gnrc_pkg.sv
// Shared constants and helpers for the generic valid/ready pipe.
package gnrc_pkg;

    // Deepest pipe the generator supports.
    localparam int GNRC_PIPE_MAX_DEPTH = 16;

    // Width of the occupancy counter: it must represent 0..2*depth entries.
    // A zero-depth pipe still gets a one-bit port.
    function automatic int gnrc_count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/gnrc_pipe_stage.sv
// One two-entry skid stage. New data always lands in the main entry; when the
// main entry is occupied and not draining, its old content slides into the
// overflow entry, which therefore always holds the older of the two.
// All outputs are functions of this stage's own flops only.
module gnrc_pipe_stage #(
    parameter type DTYPE = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic valid_i,
    input  DTYPE data_i,
    output logic ready_o,
    output logic valid_o,
    output DTYPE data_o,
    input  logic ready_i
);

    logic main_full;
    logic ovf_full;
    DTYPE main_data;
    DTYPE ovf_data;
    logic take_in;
    logic take_out;

    // The overflow entry is only ever full when the main entry is, so
    // "not both full" reduces to "overflow empty".
    assign ready_o  = ~ovf_full;
    assign valid_o  = main_full | ovf_full;
    assign data_o   = ovf_full ? ovf_data : main_data;
    assign take_in  = valid_i & ready_o;
    assign take_out = valid_o & ready_i;

    // Occupancy flags: reset and flush empty the stage, otherwise track handshakes.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i || flush_i) begin
            main_full <= 1'b0;
            ovf_full  <= 1'b0;
        end else if (ovf_full) begin
            if (take_out) begin
                ovf_full <= 1'b0;
            end
        end else if (main_full) begin
            if (take_in && !take_out) begin
                ovf_full <= 1'b1;
            end else if (!take_in && take_out) begin
                main_full <= 1'b0;
            end
        end else if (take_in) begin
            main_full <= 1'b1;
        end
    end

    // Payload registers: load only on an accepted input, never during flush.
    always_ff @(posedge clk_i) begin
        // NOTE: the payload is cleared on reset so data_o reads zero afterwards;
        // a datapath that never exposes empty entries could skip this reset.
        if (rst_i) begin
            main_data <= '0;
            ovf_data  <= '0;
        end else if (!flush_i && take_in) begin
            main_data <= data_i;
            if (main_full && !take_out) begin
                ovf_data <= main_data;
            end
        end
    end

endmodule

// File: rtl/gnrc_pipe.sv
// Generic valid/ready pipe: DEPTH cascaded two-entry skid stages with flush,
// an occupancy counter, and optional transfer/stall statistics enabled by
// defining GNRC_PIPE_STATS_EN. DEPTH=0 degenerates to a wire.
module gnrc_pipe
    import gnrc_pkg::*;
#(
    parameter int  DW    = 32,
    parameter int  DEPTH = 2,
    parameter type DTYPE = logic [DW-1:0],
    localparam int CW    = gnrc_count_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  DTYPE          data_i,
    output logic          ready_o,
    output logic          valid_o,
    output DTYPE          data_o,
    input  logic          ready_i,
    output logic [CW-1:0] count_o
`ifdef GNRC_PIPE_STATS_EN
    ,
    output logic [31:0]   xfer_cnt_o,
    output logic [31:0]   stall_cnt_o
`endif
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign ready_o = ready_i;
            assign valid_o = valid_i;
            assign data_o  = data_i;
            assign count_o = '0;
        end else begin : g_chain
            logic          stg_valid [DEPTH+1];
            logic          stg_ready [DEPTH+1];
            DTYPE          stg_data  [DEPTH+1];
            logic [CW-1:0] count_q;
            logic          in_xfer;
            logic          out_xfer;

            assign stg_valid[0]     = valid_i;
            assign stg_data[0]      = data_i;
            assign stg_ready[DEPTH] = ready_i;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                gnrc_pipe_stage #(.DTYPE(DTYPE)) u_stage (
                    .clk_i   (clk_i),
                    .rst_i   (rst_i),
                    .flush_i (flush_i),
                    .valid_i (stg_valid[i]),
                    .data_i  (stg_data[i]),
                    .ready_o (stg_ready[i]),
                    .valid_o (stg_valid[i+1]),
                    .data_o  (stg_data[i+1]),
                    .ready_i (stg_ready[i+1])
                );
            end

            // Reset acts as a hold-off on the upstream handshake; the data
            // path itself stays purely registered.
            assign ready_o  = stg_ready[0] & ~rst_i;
            assign valid_o  = stg_valid[DEPTH];
            assign data_o   = stg_data[DEPTH];
            assign in_xfer  = valid_i & ready_o;
            assign out_xfer = valid_o & ready_i;
            assign count_o  = count_q;

            // Occupancy: +1 per accepted input, -1 per delivered output.
            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    count_q <= '0;
                end else if (in_xfer && !out_xfer) begin
                    count_q <= count_q + CW'(1);
                end else if (!in_xfer && out_xfer) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    endgenerate

`ifdef GNRC_PIPE_STATS_EN
    logic [31:0] xfer_q;
    logic [31:0] stall_q;

    // Saturating statistics; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (valid_o && ready_i && (xfer_q != '1)) begin
                xfer_q <= xfer_q + 32'd1;
            end
            if (valid_o && !ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign xfer_cnt_o  = xfer_q;
    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_gnrc_pipe.sv
// Self-checking bench for gnrc_pipe: DEPTH=0 vector table, DEPTH=2 directed
// corner sequences, DEPTH=3 randomized run against a queue model.
`timescale 1ns/1ps
module tb_gnrc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // DEPTH=0 instance
    logic        v0_i, r0_i, f0_i, r0_o, v0_o;
    logic [31:0] d0_i, d0_o;
    logic [0:0]  c0_o;
    // DEPTH=2 instance
    logic        v2_i, r2_i, f2_i, r2_o, v2_o;
    logic [31:0] d2_i, d2_o;
    logic [2:0]  c2_o;
    // DEPTH=3 instance
    logic        v3_i, r3_i, f3_i, r3_o, v3_o;
    logic [31:0] d3_i, d3_o;
    logic [2:0]  c3_o;
`ifdef GNRC_PIPE_STATS_EN
    logic [31:0] x0_o, s0_o, x2_o, s2_o, x3_o, s3_o;
`endif

    gnrc_pipe #(.DEPTH(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(f0_i), .valid_i(v0_i), .data_i(d0_i),
        .ready_o(r0_o), .valid_o(v0_o), .data_o(d0_o), .ready_i(r0_i), .count_o(c0_o)
`ifdef GNRC_PIPE_STATS_EN
        , .xfer_cnt_o(x0_o), .stall_cnt_o(s0_o)
`endif
    );

    gnrc_pipe #(.DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(f2_i), .valid_i(v2_i), .data_i(d2_i),
        .ready_o(r2_o), .valid_o(v2_o), .data_o(d2_o), .ready_i(r2_i), .count_o(c2_o)
`ifdef GNRC_PIPE_STATS_EN
        , .xfer_cnt_o(x2_o), .stall_cnt_o(s2_o)
`endif
    );

    gnrc_pipe #(.DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(f3_i), .valid_i(v3_i), .data_i(d3_i),
        .ready_o(r3_o), .valid_o(v3_o), .data_o(d3_o), .ready_i(r3_i), .count_o(c3_o)
`ifdef GNRC_PIPE_STATS_EN
        , .xfer_cnt_o(x3_o), .stall_cnt_o(s3_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        v2_i = 1'b0; r2_i = 1'b0; f2_i = 1'b0; d2_i = '0;
        v3_i = 1'b0; r3_i = 1'b0; f3_i = 1'b0; d3_i = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Hold valid_i high with ready_i low on the DEPTH=2 pipe for 10 cycles.
    task automatic fill_stalled(output int acc);
        acc  = 0;
        r2_i = 1'b0;
        v2_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d2_i = 32'h11 + acc;
            #1;
            if (r2_o) acc++;
            step();
        end
        v2_i = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [31:0] d;
        logic        exp_v;
        logic        exp_r;
        logic [31:0] exp_d;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc;
        int          n;
        int          maxc;
        bit          seen;
        logic        pv;
        logic [31:0] pd;

        v0_i = 1'b0; r0_i = 1'b0; f0_i = 1'b0; d0_i = '0;
        apply_reset();

        // ---- reset state ----
        check("rst_ready", 64'(r2_o), 64'(1));
        check("rst_valid", 64'(v2_o), 64'(0));
        check("rst_count", 64'(c2_o), 64'(0));
        check("rst_data",  64'(d2_o), 64'(0));
`ifdef GNRC_PIPE_STATS_EN
        check("rst_xfer",  64'(x2_o), 64'(0));
        check("rst_stall", 64'(s2_o), 64'(0));
`endif

        // ---- DEPTH=0 pass-through table ----
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b1, 32'hA5A5_5A5A};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h0F0F_F0F0, 1'b1, 1'b0, 32'h0F0F_F0F0};
        for (int i = 0; i < 6; i++) begin
            v0_i = tbl[i].v; r0_i = tbl[i].r; f0_i = tbl[i].f; d0_i = tbl[i].d;
            step();
            check("d0_valid", 64'(v0_o), 64'(tbl[i].exp_v));
            check("d0_ready", 64'(r0_o), 64'(tbl[i].exp_r));
            check("d0_data",  64'(d0_o), 64'(tbl[i].exp_d));
            check("d0_count", 64'(c0_o), 64'(0));
        end

        // ---- back-to-back 0x11..0x18, ready_i high ----
        apply_reset();
        r2_i = 1'b1;
        maxc = 0;
        for (int k = 0; k < 12; k++) begin
            v2_i = (k < 8);
            d2_i = 32'h11 + k;
            #1;
            check("b2b_ready", 64'(r2_o), 64'(1));
            if (k < 2)  check("b2b_latency", 64'(v2_o), 64'(0));
            if (k >= 2 && k < 10) begin
                check("b2b_valid", 64'(v2_o), 64'(1));
                check("b2b_data",  64'(d2_o), 64'(32'h11 + k - 2));
            end
            if (k >= 10) check("b2b_drained", 64'(v2_o), 64'(0));
            step();
            if (int'(c2_o) > maxc) maxc = int'(c2_o);
        end
        v2_i = 1'b0;
        check("b2b_count_peak", 64'(maxc), 64'(2));

        // ---- capacity with ready_i low, then ordered drain ----
        apply_reset();
        fill_stalled(acc);
        check("cap_accepted", 64'(acc),  64'(4));
        check("cap_ready_lo", 64'(r2_o), 64'(0));
        check("cap_count",    64'(c2_o), 64'(4));
        r2_i = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (v2_o) begin
                check("cap_order", 64'(d2_o), 64'(32'h11 + n));
                n++;
            end
            step();
        end
        check("cap_drain_n",   64'(n),    64'(4));
        check("cap_drain_cnt", 64'(c2_o), 64'(0));

        // ---- flush of a full pipe with a competing input ----
        apply_reset();
        fill_stalled(acc);
        f2_i = 1'b1; v2_i = 1'b1; d2_i = 32'hAA; r2_i = 1'b0;
        step();
        f2_i = 1'b0; v2_i = 1'b0;
        #1;
        check("flush_count", 64'(c2_o), 64'(0));
        check("flush_valid", 64'(v2_o), 64'(0));
        check("flush_ready", 64'(r2_o), 64'(1));
        r2_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (v2_o) seen = 1'b1;
            step();
        end
        check("flush_no_aa", 64'(seen), 64'(0));

        // ---- flush with one entry held and the flush-cycle input accepted ----
        v2_i = 1'b1; d2_i = 32'h55; r2_i = 1'b0;
        step();
        f2_i = 1'b1; d2_i = 32'hAA;
        #1;
        check("flush1_ready", 64'(r2_o), 64'(1));
        step();
        f2_i = 1'b0; v2_i = 1'b0; r2_i = 1'b1;
        #1;
        check("flush1_count", 64'(c2_o), 64'(0));
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (v2_o) seen = 1'b1;
            step();
        end
        check("flush1_empty", 64'(seen), 64'(0));

        // ---- reset mid-stream ----
        r2_i = 1'b0; v2_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d2_i = 32'h60 + k;
            step();
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("midrst_ready", 64'(r2_o), 64'(0));
        end
        rst  = 1'b0;
        v2_i = 1'b0;
        #1;
        check("midrst_valid", 64'(v2_o), 64'(0));
        check("midrst_count", 64'(c2_o), 64'(0));
        check("midrst_data",  64'(d2_o), 64'(0));
        check("midrst_ready_rel", 64'(r2_o), 64'(1));
        r2_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (v2_o) seen = 1'b1;
        end
        check("midrst_no_stale", 64'(seen), 64'(0));

`ifdef GNRC_PIPE_STATS_EN
        // ---- statistics: 5 transfers, 3 stall cycles, flush-insensitive ----
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            v2_i = (k == 0); d2_i = 32'h01; r2_i = (k == 5);
            #1;
            if (k < 2) check("stat_pre_valid", 64'(v2_o), 64'(0));
            else       check("stat_valid",     64'(v2_o), 64'(1));
            step();
        end
        r2_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v2_i = (k < 4); d2_i = 32'h02 + k;
            step();
        end
        v2_i = 1'b0;
        check("stat_xfer",  64'(x2_o), 64'(5));
        check("stat_stall", 64'(s2_o), 64'(3));
        f2_i = 1'b1;
        step();
        f2_i = 1'b0;
        step();
        check("stat_flush_xfer",  64'(x2_o), 64'(5));
        check("stat_flush_stall", 64'(s2_o), 64'(3));
`endif

        // ---- DEPTH=3 randomized run against a queue model ----
        apply_reset();
        q.delete();
        pv = 1'b0;
        pd = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v3_i = 1'($urandom_range(0, 1));
            r3_i = 1'($urandom_range(0, 1));
            d3_i = $urandom;
            f3_i = ($urandom_range(0, 99) == 0);
            #1;
            if (pv) begin
                check("rnd_hold_valid", 64'(v3_o), 64'(1));
                check("rnd_hold_data",  64'(d3_o), 64'(pd));
            end
            if (q.size() == 0) check("rnd_empty_novalid", 64'(v3_o), 64'(0));
            if (q.size() < 2)  check("rnd_ready_free",    64'(r3_o), 64'(1));
            if (v3_o && r3_i && q.size() != 0) begin
                check("rnd_data", 64'(d3_o), 64'(q.pop_front()));
            end
            if (f3_i) q.delete();
            else if (v3_i && r3_o) q.push_back(d3_i);
            pv = v3_o & ~r3_i & ~f3_i;
            pd = d3_o;
            step();
            check("rnd_count", 64'(c3_o), 64'(q.size()));
        end
        v3_i = 1'b0; f3_i = 1'b0; r3_i = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) begin
            #1;
            if (v3_o) check("rnd_drain_data", 64'(d3_o), 64'(q.pop_front()));
            step();
        end
        check("rnd_drain_left", 64'(q.size()), 64'(0));
        check("rnd_drain_count", 64'(c3_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnrc_pipe.md
GNRC_PIPE -- requirements
Module: gnrc_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: payload width in bits, >=1; ignored if DTYPE is overridden.
REQ-002 SHALL have parameter DEPTH, default 2: number of cascaded full-registered stages, range 0..16.
REQ-003 SHALL have parameter DTYPE, default logic [DW-1:0]: payload type, overridable.
REQ-004 SHALL have port clk_i  in  1: clock, rising edge.
REQ-005 SHALL have port rst_i  in  1: reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have port flush_i  in  1: discards all stored entries.
REQ-007 SHALL have port valid_i  in  1: upstream valid.
REQ-008 SHALL have port data_i  in  DTYPE: upstream payload.
REQ-009 SHALL have port ready_o  out  1: pipe accepts data.
REQ-010 SHALL have port valid_o  out  1: downstream valid.
REQ-011 SHALL have port data_o  out  DTYPE: downstream payload.
REQ-012 SHALL have port ready_i  in  1: downstream ready.
REQ-013 SHALL have port count_o  out  CW=$clog2(2*DEPTH+1) (min 1): number of entries held.

Function
REQ-014 Transfers SHALL occur on the input side when valid_i&ready_o and on the output side when valid_o&ready_i, at the rising edge.
REQ-015 Each stage SHALL be a two-entry skid stage: main entry plus overflow entry. ready toward upstream = not both full. valid toward downstream = either full. Output = overflow entry if full, else main entry.
REQ-016 With DEPTH>=1, ready_o, valid_o and data_o SHALL be driven only from flops, with no combinational path from any input.
REQ-017 Empty-pipe latency SHALL be DEPTH cycles from input transfer to valid_o.
REQ-018 Steady-state throughput SHALL be one transfer per cycle with ready_i held high.
REQ-019 Capacity SHALL be 2*DEPTH entries; ready_o SHALL deassert only when stage 0 holds two entries.
REQ-020 Order SHALL be strictly FIFO, with no loss or duplication under any valid_i/ready_i pattern.
REQ-021 count_o SHALL increment on an input transfer only, decrement on an output transfer only, and be unchanged on simultaneous input and output transfers; it is registered.
REQ-022 With DEPTH=0: ready_o=ready_i, valid_o=valid_i, data_o=data_i, count_o=0; flush_i ignored.
REQ-023 While flush_i=1, the following cycle SHALL show all entries empty and count_o=0. An input transfer in the flush cycle SHALL be discarded. An output transfer in the flush cycle SHALL be considered completed.
REQ-024 A stage's data registers SHALL load only on that stage's input transfer and SHALL NOT load while flush_i=1.
REQ-025 valid_o SHALL NOT deassert without an output transfer or flush/reset (AXI-style stability); data_o SHALL be stable while valid_o&~ready_i.

Reset
REQ-026 When rst_i=1 at a clock edge, all stage valid flags SHALL clear, data registers SHALL become 0 and count_o SHALL become 0; rst_i takes priority over flush_i.
REQ-027 While rst_i=1, ready_o SHALL be forced 0 and inputs ignored; the first cycle after release SHALL show ready_o=1 (DEPTH>=1), valid_o=0.
REQ-028 Reset asserted mid-stream SHALL drop all held entries; no stale data SHALL appear after release.

Configuration
REQ-029 Macro GNRC_PIPE_STATS_EN, when defined, SHALL add outputs xfer_cnt_o [31:0] (output transfers) and stall_cnt_o [31:0] (cycles with valid_o&~ready_i).
REQ-030 The counters SHALL be saturating, cleared by rst_i only, and unaffected by flush_i.
REQ-031 Without GNRC_PIPE_STATS_EN, those ports and counters SHALL NOT exist.

Structure
REQ-032 Package gnrc_pkg SHALL hold the GNRC_PIPE_MAX_DEPTH=16 constant and the function deriving CW from DEPTH.
REQ-033 Sub-module gnrc_pipe_stage (one two-entry skid stage with flush, DTYPE parameter) SHALL be instantiated DEPTH times in a generate chain; count logic and stats SHALL live in gnrc_pipe.

Verification
REQ-034 DEPTH=2, ready_i=1, send 0x11..0x18 back-to-back -> 0x11 on data_o with valid_o at cycle 2; eight consecutive output transfers; count_o peaks at 2.
REQ-035 DEPTH=2, ready_i=0, valid_i=1 continuous -> exactly 4 accepted; ready_o=0 thereafter; count_o=4; then ready_i=1 -> 0x11..0x14 in order.
REQ-036 DEPTH=3, random valid_i/ready_i at 50% over 10000 cycles -> scoreboard in-order match; count_o always equals the model's occupancy.
REQ-037 DEPTH=2, full (4 entries), flush_i pulsed with valid_i=1 data 0xAA -> next cycle count_o=0, valid_o=0, ready_o=1; 0xAA never emerges.
REQ-038 Mid-stream, rst_i=1 for 2 cycles -> ready_o=0 during reset; after release valid_o=0, count_o=0, data_o=0.
REQ-039 With GNRC_PIPE_STATS_EN: 5 transfers and 3 stall cycles -> xfer_cnt_o=5, stall_cnt_o=3; flush -> values unchanged.
